mem_port_tid_arbiter: RTL and testbench
=======================================

// Module: mem_port_tid_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write-through memory port between NrPorts requesters
//  (I-cache refill, D-cache miss unit, D-cache write buffer). Allocates a transaction ID (TID)
//  per accepted request and tracks its owner. Routes each returning response to the owning requester.
//  Sits between the cache controllers and the memory/bus adapter.
// PARAMETERS
//  NrPorts      3   number of requesters (>=2)
//  PayloadWidth 64  opaque request payload bits (addr/we/data/size packed by requester)
//  TidWidth     2   TID width; pool holds 2**TidWidth outstanding transactions
// PORTS
//  clk_i             in   1                  clock
//  rst_ni            in   1                  reset, asynchronous, active-low
//  req_valid_i       in   NrPorts            per-requester request valid
//  req_ready_o       out  NrPorts            per-requester accept (one-hot or zero)
//  req_payload_i     in   NrPorts*PayloadWidth  packed payloads, port i at [i*PayloadWidth +: PayloadWidth]
//  mem_req_valid_o   out  1                  request to memory port valid
//  mem_req_ready_i   in   1                  memory port accepts
//  mem_req_payload_o out  PayloadWidth       winning payload
//  mem_req_tid_o     out  TidWidth           allocated TID
//  mem_rsp_valid_i   in   1                  response valid (always accepted)
//  mem_rsp_tid_i     in   TidWidth           TID of response
//  rsp_valid_o       out  NrPorts            one-hot response strobe to owner
//  rsp_err_o         out  1                  pulse: response TID not outstanding
//  busy_o            out  1                  any TID outstanding or output register full
// BEHAVIOUR
//  Reset: all TIDs free; rr pointer=0; output reg empty; all outputs 0.
//  Output reg: single entry {payload,tid}. mem_req_valid_o = reg full.
//   Contents are stable while valid && !ready.
//  Grant condition: (reg empty || mem_req_ready_i) && free TID exists && any req_valid_i.
//   Winner = first valid port at or after rr pointer (mod NrPorts).
//   req_ready_o[winner]=1 combinationally; reg loads next edge.
//   Latency accept->mem_req_valid_o: 1 cycle; throughput 1/cycle with ready high.
//  On grant: rr pointer <= winner+1 mod NrPorts; otherwise unchanged.
//   TID = lowest-index free entry; entry marked busy with owner=winner.
//  Response: if entry[tid] busy, rsp_valid_o[owner]=1 same cycle (combinational) and entry is freed.
//   The freed TID is grantable from the next cycle only (no same-cycle bypass).
//   If not busy: rsp_valid_o=0, rsp_err_o=1 for that cycle; table unchanged.
//  Simultaneous alloc and free of different TIDs in one cycle: both take effect.
//  Pool full: req_ready_o=0 for all ports; the output reg still drains.
//  Requesters must hold valid/payload until ready (not checked).
//  Reset mid-operation clears table and reg. Late responses afterwards report rsp_err_o.
// CONFIGURATION
//  MEM_ARB_STALL_CNT_EN defined: add output stall_cnt_o [31:0], saturating.
//   Increments each cycle any req_valid_i=1 and no grant occurs. Reset 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package mem_arb_pkg: tid_entry_t {busy, owner[$clog2(NrPorts)-1:0]},
//   out_reg_t {valid, payload, tid}, and the function giving the lowest free index.
//  Sub-module mem_arb_rr_pick: combinational rotate-priority picker
//   (valid vector, pointer -> one-hot grant, index, any).
// TESTING
//  1. Ports 0,1,2 valid continuously, ready=1, responses returned 1 cycle later ->
//     grants 0,1,2,0,...; TIDs 0,1,0,1...; no rsp_err_o.
//  2. Port1 only, ready=0, 5 cycles -> 4 accepts max (TID 0..3 after drain); while full, req_ready_o=0.
//     Pool full with no responses: no further grant.
//  3. mem_req_ready_i=0 with reg full -> payload/tid held stable; grant resumes the same cycle ready=1.
//  4. Response on TID2 owned by port2 while port0 is granted -> rsp_valid_o=3'b100; port0 gets lowest free TID.
//     TID2 is not reused that cycle.
//  5. Response on free TID1 -> rsp_err_o=1 for one cycle, rsp_valid_o=0, table unchanged.
//  6. rst_ni asserted with 3 TIDs outstanding -> busy_o=0 immediately.
//     A later response on TID0 -> rsp_err_o=1.
//     With MEM_ARB_STALL_CNT_EN: 10 blocked cycles -> stall_cnt_o=10.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and helpers for the memory-port TID arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
// Struct field widths follow the package constants below; the arbiter's
// parameters default to them, so a different configuration is set here.
package mem_arb_pkg;

  localparam int unsigned NrPortsP      = 3;
  localparam int unsigned PayloadWidthP = 64;
  localparam int unsigned TidWidthP     = 2;
  localparam int unsigned OwnerWidthP   = (NrPortsP > 1) ? $clog2(NrPortsP) : 1;
  localparam int unsigned NrTidsP       = 1 << TidWidthP;

  typedef struct packed {
    logic                   busy;
    logic [OwnerWidthP-1:0] owner;
  } tid_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [PayloadWidthP-1:0] payload;
    logic [TidWidthP-1:0]     tid;
  } out_reg_t;

  // Lowest-index clear bit of the busy vector; result is meaningless when all are busy.
  function automatic logic [TidWidthP-1:0] lowest_free(input logic [NrTidsP-1:0] busy);
    logic [TidWidthP-1:0] idx;
    idx = '0;
    for (int i = int'(NrTidsP) - 1; i >= 0; i--) begin
      if (!busy[i]) idx = TidWidthP'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Purpose: rotate-priority picker; first valid requester at or after ptr_i (mod N).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports: valid_i request vector, ptr_i start index (< N), gnt_o one-hot winner,
//        idx_o winner index, any_o at least one request valid.
module mem_arb_rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    logic [IdxW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IdxW'((32'(ptr_i) + k) % N);
      if (!any_o && valid_i[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_tid_arbiter.sv
// Purpose: round-robin share of one memory port among NrPorts requesters with TID allocation and response routing.
// Latency: accept -> mem_req_valid_o 1 cycle; response -> rsp_valid_o same cycle (combinational).
// Backpressure: single output register drains on mem_req_ready_i; no grant when it cannot load or the TID pool is full.
// Ports: req_valid_i/req_ready_o/req_payload_i requester side; mem_req_* memory request with TID;
//        mem_rsp_valid_i/mem_rsp_tid_i responses (always accepted); rsp_valid_o one-hot owner strobe;
//        rsp_err_o unknown-TID pulse; busy_o anything outstanding.
// Optional: MEM_ARB_STALL_CNT_EN adds stall_cnt_o, a saturating count of cycles with requests but no grant.
module mem_port_tid_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NrPorts      = NrPortsP,
  parameter int unsigned PayloadWidth = PayloadWidthP,
  parameter int unsigned TidWidth     = TidWidthP
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrPorts-1:0]              req_valid_i,
  output logic [NrPorts-1:0]              req_ready_o,
  input  logic [NrPorts*PayloadWidth-1:0] req_payload_i,
  output logic                            mem_req_valid_o,
  input  logic                            mem_req_ready_i,
  output logic [PayloadWidth-1:0]         mem_req_payload_o,
  output logic [TidWidth-1:0]             mem_req_tid_o,
  input  logic                            mem_rsp_valid_i,
  input  logic [TidWidth-1:0]             mem_rsp_tid_i,
  output logic [NrPorts-1:0]              rsp_valid_o,
  output logic                            rsp_err_o,
`ifdef MEM_ARB_STALL_CNT_EN
  output logic [31:0]                     stall_cnt_o,
`endif
  output logic                            busy_o
);

  localparam int unsigned NrTids = 1 << TidWidth;
  localparam int unsigned OwnW   = OwnerWidthP;

  tid_entry_t                table_q [NrTids];
  tid_entry_t                table_d [NrTids];
  out_reg_t                  out_q, out_d;
  logic [OwnW-1:0]           rr_q, rr_d;

  logic [PayloadWidth-1:0]   port_payload [NrPorts];
  logic [NrTids-1:0]         busy_vec;
  logic [NrPorts-1:0]        pick_gnt;
  logic [OwnW-1:0]           pick_idx;
  logic                      pick_any;
  logic [TidWidth-1:0]       alloc_tid;
  logic                      grant;
  logic                      rsp_hit;
  tid_entry_t                rsp_entry;

  for (genvar g = 0; g < NrPorts; g++) begin : g_unpack
    assign port_payload[g] = req_payload_i[g*PayloadWidth +: PayloadWidth];
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < int'(NrTids); i++) busy_vec[i] = table_q[i].busy;
  end

  mem_arb_rr_pick #(
    .N    (NrPorts),
    .IdxW (OwnW)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Allocation looks only at registered state, so a TID freed this cycle is not reused until the next.
  assign alloc_tid = lowest_free(busy_vec);
  assign grant     = (!out_q.valid || mem_req_ready_i) && !(&busy_vec) && pick_any;

  assign rsp_entry = table_q[mem_rsp_tid_i];
  assign rsp_hit   = mem_rsp_valid_i && rsp_entry.busy;

  assign req_ready_o       = grant ? pick_gnt : '0;
  assign rsp_valid_o       = rsp_hit ? (NrPorts'(1) << rsp_entry.owner) : '0;
  assign rsp_err_o         = mem_rsp_valid_i && !rsp_entry.busy;
  assign mem_req_valid_o   = out_q.valid;
  assign mem_req_payload_o = out_q.payload;
  assign mem_req_tid_o     = out_q.tid;
  assign busy_o            = (|busy_vec) || out_q.valid;

  always_comb begin
    table_d = table_q;
    out_d   = out_q;
    rr_d    = rr_q;
    // Freed entry was busy and the allocated one was free, so the two never collide.
    if (rsp_hit) table_d[mem_rsp_tid_i].busy = 1'b0;
    if (grant) begin
      table_d[alloc_tid] = '{busy: 1'b1, owner: pick_idx};
      out_d              = '{valid: 1'b1, payload: port_payload[pick_idx], tid: alloc_tid};
      rr_d               = (32'(pick_idx) == NrPorts - 1) ? '0 : pick_idx + 1'b1;
    end else if (mem_req_ready_i) begin
      out_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrTids); i++) table_q[i] <= '0;
      out_q <= '0;
      rr_q  <= '0;
    end else begin
      table_q <= table_d;
      out_q   <= out_d;
      rr_q    <= rr_d;
    end
  end

`ifdef MEM_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|req_valid_i) && !grant && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_tid_arbiter.sv
// Purpose: self-checking bench for mem_port_tid_arbiter against a queue/array-level model.
// Latency: n/a (testbench).
// Backpressure: memory ready and responses are driven per directed step.
module tb_mem_port_tid_arbiter;

  logic         clk;
  logic         rst_n;
  logic [2:0]   req_valid;
  logic [2:0]   req_ready;
  logic [191:0] req_payload;
  logic         mem_valid;
  logic         mem_ready;
  logic [63:0]  mem_payload;
  logic [1:0]   mem_tid;
  logic         rsp_valid;
  logic [1:0]   rsp_tid;
  logic [2:0]   rsp_out;
  logic         rsp_err;
  logic         busy;
`ifdef MEM_ARB_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  mem_port_tid_arbiter dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_payload_i     (req_payload),
    .mem_req_valid_o   (mem_valid),
    .mem_req_ready_i   (mem_ready),
    .mem_req_payload_o (mem_payload),
    .mem_req_tid_o     (mem_tid),
    .mem_rsp_valid_i   (rsp_valid),
    .mem_rsp_tid_i     (rsp_tid),
    .rsp_valid_o       (rsp_out),
    .rsp_err_o         (rsp_err),
`ifdef MEM_ARB_STALL_CNT_EN
    .stall_cnt_o       (stall_cnt),
`endif
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Model: owner per TID (-1 = free), one-entry output register, rr pointer, stall count.
  int          owner_m [4];
  bit          ov_m;
  logic [63:0] op_m;
  logic [1:0]  ot_m;
  int          rr_m;
  int unsigned stall_m;

  // Per-cycle observations for directed literal checks.
  int          last_win;
  int          last_tid;
  logic [2:0]  last_rdy;
  logic [2:0]  last_rsp;
  logic        last_err;

  localparam logic [63:0] P0A = 64'h0000_0000_AAAA_0000;
  localparam logic [63:0] P1A = 64'h0000_0000_BBBB_1111;
  localparam logic [63:0] P2A = 64'h0000_0000_CCCC_2222;
  localparam logic [63:0] P0B = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] P1B = 64'hDEAD_BEEF_0000_0002;
  localparam logic [63:0] P2B = 64'hDEAD_BEEF_0000_0003;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 4; t++) owner_m[t] = -1;
    ov_m    = 1'b0;
    op_m    = '0;
    ot_m    = '0;
    rr_m    = 0;
    stall_m = 0;
  endtask

  // Called at posedge+1 with inputs already driven; compares at negedge, advances the model after the edge.
  task automatic cycle();
    int         win;
    int         tid;
    bit         g;
    bit         hit;
    bit         any_busy;
    logic [2:0] exp_rdy;
    logic [2:0] exp_rsp;
    logic       exp_err;
    logic [63:0] win_pl;
    @(negedge clk);
    win = -1;
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (rr_m + k) % 3;
      if (win < 0 && req_valid[j]) win = j;
    end
    tid = -1;
    for (int t = 3; t >= 0; t--) if (owner_m[t] < 0) tid = t;
    g       = (!ov_m || mem_ready) && (tid >= 0) && (win >= 0);
    exp_rdy = g ? (3'b001 << win) : 3'b000;
    hit     = rsp_valid && (owner_m[int'(rsp_tid)] >= 0);
    exp_rsp = hit ? (3'b001 << owner_m[int'(rsp_tid)]) : 3'b000;
    exp_err = rsp_valid && !hit;
    any_busy = ov_m;
    for (int t = 0; t < 4; t++) if (owner_m[t] >= 0) any_busy = 1'b1;

    chk("req_ready", req_ready, exp_rdy);
    chk("mem_valid", mem_valid, ov_m);
    if (ov_m) begin
      chk("mem_payload", mem_payload, op_m);
      chk("mem_tid", mem_tid, ot_m);
    end
    chk("rsp_valid", rsp_out, exp_rsp);
    chk("rsp_err", rsp_err, exp_err);
    chk("busy", busy, any_busy);
`ifdef MEM_ARB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stall_m);
`endif
    last_win = g ? win : -1;
    last_tid = g ? tid : -1;
    last_rdy = req_ready;
    last_rsp = rsp_out;
    last_err = rsp_err;
    win_pl   = (win >= 0) ? req_payload[win*64 +: 64] : '0;

    @(posedge clk);
    #1;
    if (hit) owner_m[int'(rsp_tid)] = -1;
    if (g) begin
      owner_m[tid] = win;
      rr_m = (win + 1) % 3;
      ov_m = 1'b1;
      op_m = win_pl;
      ot_m = 2'(tid);
    end else if (mem_ready) begin
      ov_m = 1'b0;
    end
    if ((|req_valid) && !g && stall_m != 32'hFFFF_FFFF) stall_m++;
  endtask

  int wins [6];
  int tids [6];
  int dut_tids [6];
  int accepts;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req_valid = '0;
    mem_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_tid = '0;
    req_payload = {P2A, P1A, P0A};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_valid", mem_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_req_ready", req_ready, 3'b000);
    chk("reset_rsp_valid", rsp_out, 3'b000);
    chk("reset_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: all ports requesting, ready high, each request answered the cycle it is handed over.
    req_valid = 3'b111;
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rsp_valid = ov_m;
      rsp_tid   = ot_m;
      cycle();
      wins[c]     = last_win;
      tids[c]     = last_tid;
      dut_tids[c] = int'(mem_tid);
    end
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t1_win%0d", c), 64'(wins[c]), 64'(c % 3));
      chk($sformatf("t1_tid%0d", c), 64'(tids[c]), 64'(c % 2));
      chk($sformatf("t1_dut_tid%0d", c), 64'(dut_tids[c]), 64'(c % 2));
    end
    req_valid = '0;
    rsp_valid = ov_m;
    rsp_tid   = ot_m;
    cycle();
    rsp_valid = 1'b0;
    cycle();
    chk("t1_idle_busy", busy, 1'b0);

    // 2: port1 alone, ready low then high, no responses: exactly four TIDs handed out.
    req_valid = 3'b010;
    mem_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (last_win >= 0) accepts++;
    end
    chk("t2_stalled_accepts", 64'(accepts), 64'd1);
    chk("t2_stalled_ready", last_rdy, 3'b000);
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c < 3) chk($sformatf("t2_tid%0d", c + 1), 64'(last_tid), 64'(c + 1));
      if (last_win >= 0) accepts++;
    end
    chk("t2_total_accepts", 64'(accepts), 64'd4);
    chk("t2_full_ready", last_rdy, 3'b000);
    chk("t2_drained", mem_valid, 1'b0);
    chk("t2_busy", busy, 1'b1);
    req_valid = '0;
    for (int t = 0; t < 4; t++) begin
      rsp_valid = 1'b1;
      rsp_tid   = 2'(t);
      cycle();
      chk($sformatf("t2_rsp_tid%0d", t), last_rsp, 3'b010);
    end
    rsp_valid = 1'b0;

    // 3: output held while ready is low; grant resumes in the cycle ready returns.
    req_payload = {P2B, P1B, P0B};
    req_valid = 3'b001;
    mem_ready = 1'b0;
    cycle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t3_hold_payload", mem_payload, P0B);
      chk("t3_hold_tid", mem_tid, 2'd0);
      chk("t3_hold_ready", last_rdy, 3'b000);
    end
    mem_ready = 1'b1;
    cycle();
    chk("t3_resume_ready", last_rdy, 3'b001);
    chk("t3_resume_tid", 64'(last_tid), 64'd1);

    // 4: response for port2's TID2 in the same cycle port0 is granted.
    req_valid = 3'b100;
    cycle();
    chk("t4_p2_tid", 64'(last_tid), 64'd2);
    req_valid = 3'b001;
    rsp_valid = 1'b1;
    rsp_tid   = 2'd2;
    cycle();
    chk("t4_rsp_owner", last_rsp, 3'b100);
    chk("t4_p0_win", 64'(last_win), 64'd0);
    chk("t4_no_reuse_tid", 64'(last_tid), 64'd3);

    // 5: a response for a TID that is no longer outstanding.
    req_valid = '0;
    rsp_tid   = 2'd1;
    cycle();
    chk("t5_first_rsp", last_rsp, 3'b001);
    cycle();
    chk("t5_err", last_err, 1'b1);
    chk("t5_err_rsp", last_rsp, 3'b000);
    rsp_valid = 1'b0;
    cycle();
    chk("t5_err_gone", last_err, 1'b0);
    chk("t5_table_kept", busy, 1'b1);

    // 6: reset with three TIDs outstanding, then a stale response.
    req_valid = 3'b010;
    cycle();
    chk("t6_third_tid", 64'(last_tid), 64'd1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_async", busy, 1'b0);
    chk("t6_mem_valid_async", mem_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_valid = 1'b1;
    rsp_tid   = 2'd0;
    cycle();
    chk("t6_late_err", last_err, 1'b1);
    rsp_valid = 1'b0;

    // Blocked requester: one grant, then ten stalled cycles.
    req_valid = 3'b001;
    mem_ready = 1'b0;
    for (int c = 0; c < 11; c++) cycle();
`ifdef MEM_ARB_STALL_CNT_EN
    chk("t6_stall_cnt", stall_cnt, 32'd10);
`endif
    chk("t6_model_stall", 64'(stall_m), 64'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
